// File: rtl/me_seq_ctrl.sv
// me_seq_ctrl -- top-level sequencer of the full-search block-matching
// motion-estimation chip.
//
// Flow: an init pulse starts a frame. The current block is then copied from
// the 32-bit pad bus into the current-block buffer, followed by the search
// window into the search-window buffer. Every candidate displacement is then
// handed to the SAD processing array, one at a time, in raster order (dx
// inner, dy outer). The minimum SAD is tracked. Finally the winning motion
// vector and its SAD are shifted out MSB first on a single serial pad.
//
// Ports:
//   clk         chip clock
//   rst_n       synchronous active-low reset
//   init        start / restart pulse, sampled every clock
//   input_raw   pixel word from pads (4 pixels, pixel 0 in [31:24])
//   cur_we      current-block buffer write enable
//   cur_addr    current-block buffer word address
//   sw_we       search-window buffer write enable
//   sw_addr     search-window buffer word address
//   wdata       registered copy of input_raw, paired with cur_we/sw_we
//   cand_req    one-cycle request to the PE array
//   cand_dx/dy  signed candidate displacement, stable until sad_valid
//   sad_valid   PE array result strobe
//   sad         SAD of the outstanding candidate
//   serial_out  result frame: start bit, mv_x, mv_y, sad (MSB first)
//   busy        high whenever the sequencer is not idle
//   done        one-cycle pulse after the last serial bit
module me_seq_ctrl #(
  parameter int WORD_WIDTH = 8,
  parameter int BLK_N      = 16,
  parameter int RANGE_P    = 8,
  parameter int MV_W       = 5,
  parameter int SAD_W      = 16
) (
  input  logic                                                    clk,
  input  logic                                                    rst_n,
  input  logic                                                    init,
  input  logic [31:0]                                             input_raw,
  output logic                                                    cur_we,
  output logic [$clog2(BLK_N*BLK_N/4)-1:0]                        cur_addr,
  output logic                                                    sw_we,
  output logic [$clog2((BLK_N+2*RANGE_P)*(BLK_N+2*RANGE_P)/4)-1:0] sw_addr,
  output logic [31:0]                                             wdata,
  output logic                                                    cand_req,
  output logic [MV_W-1:0]                                         cand_dx,
  output logic [MV_W-1:0]                                         cand_dy,
  input  logic                                                    sad_valid,
  input  logic [SAD_W-1:0]                                        sad,
  output logic                                                    serial_out,
  output logic                                                    busy,
  output logic                                                    done
);

  localparam int CUR_WORDS = BLK_N * BLK_N / 4;
  localparam int SW_EDGE   = BLK_N + 2 * RANGE_P;
  localparam int SW_WORDS  = SW_EDGE * SW_EDGE / 4;
  localparam int CUR_AW    = $clog2(CUR_WORDS);
  localparam int SW_AW     = $clog2(SW_WORDS);
  localparam int CNT_W     = (SW_AW > CUR_AW) ? SW_AW : CUR_AW;
  localparam int FRAME_W   = 1 + 2 * MV_W + SAD_W;
  localparam int BIT_W     = $clog2(FRAME_W);

  localparam logic [CNT_W-1:0] CUR_LAST = CNT_W'(CUR_WORDS - 1);
  localparam logic [CNT_W-1:0] SW_LAST  = CNT_W'(SW_WORDS - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_W - 1);
  localparam logic [MV_W-1:0]  MV_MIN   = MV_W'(-RANGE_P);
  localparam logic [MV_W-1:0]  MV_MAX   = MV_W'(RANGE_P);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD_CUR = 3'd1,
    LOAD_SW  = 3'd2,
    REQ      = 3'd3,
    WAIT     = 3'd4,
    SEND     = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                cur_we_q, cur_we_d;
  logic                sw_we_q, sw_we_d;
  logic [CUR_AW-1:0]   cur_addr_q, cur_addr_d;
  logic [SW_AW-1:0]    sw_addr_q, sw_addr_d;
  logic [MV_W-1:0]     dx_q, dx_d;
  logic [MV_W-1:0]     dy_q, dy_d;
  logic [MV_W-1:0]     best_x_q, best_x_d;
  logic [MV_W-1:0]     best_y_q, best_y_d;
  logic [SAD_W-1:0]    best_sad_q, best_sad_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [FRAME_W-1:0]  shift_q, shift_d;
  logic                done_q, done_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wdata_d    = wdata_q;
    cur_we_d   = 1'b0;
    sw_we_d    = 1'b0;
    cur_addr_d = cur_addr_q;
    sw_addr_d  = sw_addr_q;
    dx_d       = dx_q;
    dy_d       = dy_q;
    best_x_d   = best_x_q;
    best_y_d   = best_y_q;
    best_sad_d = best_sad_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    done_d     = 1'b0;

    if (init) begin
      // Restart from any state: the word captured this cycle is dropped and
      // the whole frame (search results included) starts over.
      state_d    = LOAD_CUR;
      cnt_d      = '0;
      dx_d       = '0;
      dy_d       = '0;
      best_x_d   = '0;
      best_y_d   = '0;
      best_sad_d = '1;
      bit_d      = '0;
    end else begin
      case (state_q)
        LOAD_CUR: begin
          wdata_d    = input_raw;
          cur_we_d   = 1'b1;
          cur_addr_d = cnt_q[CUR_AW-1:0];
          if (cnt_q == CUR_LAST) begin
            cnt_d   = '0;
            state_d = LOAD_SW;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        LOAD_SW: begin
          wdata_d   = input_raw;
          sw_we_d   = 1'b1;
          sw_addr_d = cnt_q[SW_AW-1:0];
          if (cnt_q == SW_LAST) begin
            cnt_d      = '0;
            state_d    = REQ;
            dx_d       = MV_MIN;
            dy_d       = MV_MIN;
            best_x_d   = '0;
            best_y_d   = '0;
            best_sad_d = '1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        REQ: begin
          state_d = WAIT;
        end

        WAIT: begin
          if (sad_valid) begin
            // Strict compare: on a tie the earlier candidate stays. The
            // all-ones start value exceeds any reachable SAD, so the first
            // candidate always wins.
            if (sad < best_sad_q) begin
              best_sad_d = sad;
              best_x_d   = dx_q;
              best_y_d   = dy_q;
            end
            if ((dx_q == MV_MAX) && (dy_q == MV_MAX)) begin
              state_d = SEND;
              bit_d   = '0;
              // Built from the _d values so the last candidate is included.
              shift_d = {1'b1, best_x_d, best_y_d, best_sad_d};
            end else begin
              if (dx_q == MV_MAX) begin
                dx_d = MV_MIN;
                dy_d = dy_q + 1'b1;
              end else begin
                dx_d = dx_q + 1'b1;
              end
              state_d = REQ;
            end
          end
        end

        SEND: begin
          shift_d = {shift_q[FRAME_W-2:0], 1'b0};
          if (bit_q == BIT_LAST) begin
            bit_d   = '0;
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      wdata_q    <= '0;
      cur_we_q   <= 1'b0;
      sw_we_q    <= 1'b0;
      cur_addr_q <= '0;
      sw_addr_q  <= '0;
      dx_q       <= '0;
      dy_q       <= '0;
      best_x_q   <= '0;
      best_y_q   <= '0;
      best_sad_q <= '1;
      bit_q      <= '0;
      shift_q    <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wdata_q    <= wdata_d;
      cur_we_q   <= cur_we_d;
      sw_we_q    <= sw_we_d;
      cur_addr_q <= cur_addr_d;
      sw_addr_q  <= sw_addr_d;
      dx_q       <= dx_d;
      dy_q       <= dy_d;
      best_x_q   <= best_x_d;
      best_y_q   <= best_y_d;
      best_sad_q <= best_sad_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      done_q     <= done_d;
    end
  end

  assign cur_we     = cur_we_q;
  assign cur_addr   = cur_addr_q;
  assign sw_we      = sw_we_q;
  assign sw_addr    = sw_addr_q;
  assign wdata      = wdata_q;
  assign cand_req   = (state_q == REQ);
  assign cand_dx    = dx_q;
  assign cand_dy    = dy_q;
  assign serial_out = (state_q == SEND) & shift_q[FRAME_W-1];
  assign busy       = (state_q != IDLE);
  assign done       = done_q;

endmodule

// File: tb/tb_me_seq_ctrl.sv
// Directed bench for me_seq_ctrl at default parameters: load sequencing,
// candidate walk with a 3-cycle PE model, serial result frames, tie handling,
// restart during the search and reset during the serial frame.
module tb_me_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        init = 1'b0;
  logic [31:0] input_raw = '0;
  logic        sad_valid = 1'b0;
  logic [15:0] sad = '0;

  logic        cur_we, sw_we, cand_req, serial_out, busy, done;
  logic [5:0]  cur_addr;
  logic [7:0]  sw_addr;
  logic [31:0] wdata;
  logic [4:0]  cand_dx, cand_dy;

  int n_cmp = 0;
  int n_bad = 0;

  // Expected frames: start bit, mv_x, mv_y, sad.
  localparam logic [26:0] FRAME_A = 27'b1_00011_11110_0000000000100101; // (+3,-2) sad 37
  localparam logic [26:0] FRAME_B = 27'b1_11111_00000_0000000000000101; // (-1,0) sad 5

  always #5 clk = ~clk;

  me_seq_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .init       (init),
    .input_raw  (input_raw),
    .cur_we     (cur_we),
    .cur_addr   (cur_addr),
    .sw_we      (sw_we),
    .sw_addr    (sw_addr),
    .wdata      (wdata),
    .cand_req   (cand_req),
    .cand_dx    (cand_dx),
    .cand_dy    (cand_dy),
    .sad_valid  (sad_valid),
    .sad        (sad),
    .serial_out (serial_out),
    .busy       (busy),
    .done       (done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] all_out();
    return 64'({cur_we, cur_addr, sw_we, sw_addr, wdata, cand_req,
                cand_dx, cand_dy, serial_out, busy, done});
  endfunction

  // PE stimulus tables (mode 0: single minimum, mode 1: tie).
  function automatic logic [15:0] sad_of(input int mode, input int dx, input int dy);
    if (mode == 0) return ((dx == 3) && (dy == -2)) ? 16'd37 : 16'd1000;
    return ((dy == 0) && ((dx == -1) || (dx == 4))) ? 16'd5 : 16'd100;
  endfunction

  // Runs one frame starting at the first negedge after init was sampled.
  // abort_c >= 0: assert init during WAIT of that candidate index and return.
  // rst_bit >= 0: pulse rst_n while that serial bit is on the line and return.
  task automatic body(input int mode, input int abort_c, input int rst_bit,
                      input logic [26:0] exp_frame, output bit aborted);
    int cnt, c, edx, edy, cdx, cdy, cyc, last_req;
    logic [4:0]  e5;
    logic [26:0] frame;
    aborted = 1'b0;

    @(negedge clk);
    init = 1'b0;
    input_raw = 32'd0;
    sad_valid = 1'b0;
    chk("start_busy", 64'(busy), 64'd1);
    chk("start_quiet", 64'({cur_we, sw_we, cand_req, serial_out, done}), 64'd0);

    for (int j = 2; j <= 321; j++) begin
      @(negedge clk);
      input_raw = 32'(j - 1);
      if (j <= 65) begin
        chk("cur_write", 64'({cur_we, sw_we, cur_addr, wdata}),
            64'({2'b10, 6'(j - 2), 32'(j - 2)}));
      end else begin
        chk("sw_write", 64'({cur_we, sw_we, sw_addr, wdata}),
            64'({2'b01, 8'(j - 66), 32'(j - 2)}));
      end
    end

    cnt = 0; c = 0; edx = -8; edy = -8; cdx = 0; cdy = 0; cyc = 0; last_req = 0;
    forever begin
      if (cnt > 0) begin
        e5 = 5'(cdx);
        chk("dx_stable", 64'(cand_dx), 64'(e5));
        cnt--;
        if (cnt == 0) begin
          sad_valid = 1'b1;
          sad = sad_of(mode, cdx, cdy);
        end else begin
          sad_valid = 1'b0;
        end
      end else begin
        sad_valid = 1'b0;
      end
      if ((abort_c >= 0) && (c == abort_c + 1) && (cnt == 2)) begin
        init = 1'b1;
        sad_valid = 1'b0;
        aborted = 1'b1;
        return;
      end
      if (cand_req) begin
        e5 = 5'(edx);
        chk("cand_dx", 64'(cand_dx), 64'(e5));
        e5 = 5'(edy);
        chk("cand_dy", 64'(cand_dy), 64'(e5));
        if (c > 0) chk("req_spacing", 64'(cyc - last_req), 64'd4);
        last_req = cyc;
        cdx = edx; cdy = edy;
        edx++;
        if (edx > 8) begin
          edx = -8;
          edy++;
        end
        c++;
        cnt = 3;
      end
      chk("search_quiet", 64'({done, serial_out}), 64'd0);
      if ((c == 289) && (cnt == 0)) break;
      @(negedge clk);
      cyc++;
      if (cyc > 2000) begin
        chk("search_timeout", 64'(c), 64'd289);
        return;
      end
    end

    frame = '0;
    for (int b = 0; b < 27; b++) begin
      @(negedge clk);
      sad_valid = 1'b0;
      chk("send_busy", 64'({busy, done, cand_req}), 64'b100);
      frame = {frame[25:0], serial_out};
      if (b == rst_bit) begin
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("reset_mid_send", all_out(), 64'd0);
        return;
      end
    end
    chk("frame", 64'(frame), 64'(exp_frame));
    @(negedge clk);
    chk("done_pulse", 64'({done, busy, serial_out}), 64'b100);
    @(negedge clk);
    chk("done_low", 64'({done, busy}), 64'd0);
  endtask

  initial begin
    bit ab;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("reset_outs", all_out(), 64'd0);
    input_raw = 32'hDEADBEEF;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_outs", all_out(), 64'd0);
    end

    // Frame with a single minimum at (+3,-2).
    @(negedge clk); init = 1'b1;
    body(0, -1, -1, FRAME_A, ab);
    $display("frame A complete");

    // Equal minima at (-1,0) and (+4,0): earlier one is reported.
    @(negedge clk); init = 1'b1;
    body(1, -1, -1, FRAME_B, ab);
    $display("frame B (tie) complete");

    // Restart during WAIT of candidate 50, then a full frame.
    @(negedge clk); init = 1'b1;
    body(0, 50, -1, FRAME_A, ab);
    chk("abort_taken", 64'(ab), 64'd1);
    body(1, -1, -1, FRAME_B, ab);
    $display("restart frame complete");

    // Reset during serial bit 10, then stray sad_valid in IDLE.
    @(negedge clk); init = 1'b1;
    body(0, -1, 10, FRAME_A, ab);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      sad_valid = i[0];
      sad = 16'd1;
      if (i > 0) chk("stray_valid_idle", 64'({busy, cand_req, serial_out, done}), 64'd0);
    end
    sad_valid = 1'b0;
    $display("reset mid-send complete");

    // Recovery frame after reset.
    @(negedge clk); init = 1'b1;
    body(0, -1, -1, FRAME_A, ab);
    $display("recovery frame complete");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
